// File: rtl/flag_pkg.sv
// flag_pkg: flag indices, default width and the stack-operation decode shared by the flag shadow stack
package flag_pkg;

    localparam int FLAG_C      = 0;
    localparam int FLAG_Z      = 1;
    localparam int N_FLAGS_DEF = 2;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_PUSH,
        OP_POP,
        OP_SWAP,
        OP_OVF,
        OP_UNF
    } stk_op_e;

    // A simultaneous push+pop on an empty stack degrades to a plain push, so no underflow is flagged
    function automatic stk_op_e decode_op(input logic push, input logic pop, input logic empty, input logic full);
        if (push && pop) return empty ? OP_PUSH : OP_SWAP;
        if (push)        return full  ? OP_OVF  : OP_PUSH;
        if (pop)         return empty ? OP_UNF  : OP_POP;
        return OP_HOLD;
    endfunction

endpackage

// File: rtl/flag_cell.sv
// flag_cell: one live flag bit with restore > clr > set > ld > hold precedence
module flag_cell (
    input  logic clk,
    input  logic rst,
    input  logic i_restore,
    input  logic i_restore_val,
    input  logic i_clr,
    input  logic i_set,
    input  logic i_ld,
    input  logic i_din,
    output logic o_q
);

    logic r_q;

    // Restore from the shadow stack wins over every per-flag control
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_q <= 1'b0;
        else if (i_restore)   r_q <= i_restore_val;
        else if (i_clr)       r_q <= 1'b0;
        else if (i_set)       r_q <= 1'b1;
        else if (i_ld)        r_q <= i_din;
    end

    assign o_q = r_q;

endmodule

// File: rtl/flag_shadow_stack.sv
// flag_shadow_stack: live flag register with a shadow stack saved on interrupt entry and restored on return
module flag_shadow_stack
    import flag_pkg::*;
#(
    parameter int N_FLAGS = N_FLAGS_DEF,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_FLAGS-1:0]         flg_din,
    input  logic [N_FLAGS-1:0]         flg_ld,
    input  logic [N_FLAGS-1:0]         flg_set,
    input  logic [N_FLAGS-1:0]         flg_clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       err_clr,
    output logic [N_FLAGS-1:0]         flags_out,
    output logic [$clog2(DEPTH+1)-1:0] depth_cnt,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf_err,
    output logic                       unf_err
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [N_FLAGS-1:0] r_stk [DEPTH];
    logic [CW-1:0]      r_cnt;
    logic               r_ovf;
    logic               r_unf;

    logic [N_FLAGS-1:0] w_flags;
    logic [N_FLAGS-1:0] w_top;
    logic [CW-1:0]      w_top_idx;
    logic [CW-1:0]      w_wr_idx;
    logic               w_wr_en;
    logic               w_restore;
    logic               w_full;
    logic               w_empty;
    stk_op_e            w_op;

    assign w_full  = (r_cnt == CW'(DEPTH));
    assign w_empty = (r_cnt == '0);

    // Decode the stack operation; a swap writes over the top slot, a push writes the next free slot
    always_comb begin
        w_op      = decode_op(push, pop, w_empty, w_full);
        w_top_idx = r_cnt - CW'(1);
        w_wr_en   = (w_op == OP_PUSH) || (w_op == OP_SWAP);
        w_wr_idx  = (w_op == OP_SWAP) ? w_top_idx : r_cnt;
        w_restore = (w_op == OP_POP) || (w_op == OP_SWAP);
    end

    // Read mux for the current top-of-stack entry
    always_comb begin
        w_top = '0;
        for (int i = 0; i < DEPTH; i++)
            if (w_top_idx == CW'(i)) w_top = r_stk[i];
    end

    // Shadow entries carry no reset; a slot is only ever read after being written
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            if (w_wr_en && w_wr_idx == CW'(i)) r_stk[i] <= w_flags;
    end

    // Depth counter moves only on accepted pushes and pops; swaps and dropped ops leave it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_cnt <= '0;
        else if (w_op == OP_PUSH) r_cnt <= r_cnt + CW'(1);
        else if (w_op == OP_POP)  r_cnt <= r_cnt - CW'(1);
    end

    // Sticky errors; a fresh error in the err_clr cycle keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= (w_op == OP_OVF) || (r_ovf && !err_clr);
            r_unf <= (w_op == OP_UNF) || (r_unf && !err_clr);
        end
    end

    for (genvar b = 0; b < N_FLAGS; b++) begin : g_cell
        flag_cell u_cell (
            .clk           (clk),
            .rst           (rst),
            .i_restore     (w_restore),
            .i_restore_val (w_top[b]),
            .i_clr         (flg_clr[b]),
            .i_set         (flg_set[b]),
            .i_ld          (flg_ld[b]),
            .i_din         (flg_din[b]),
            .o_q           (w_flags[b])
        );
    end

    assign flags_out = w_flags;
    assign depth_cnt = r_cnt;
    assign full      = w_full;
    assign empty     = w_empty;
    assign ovf_err   = r_ovf;
    assign unf_err   = r_unf;

endmodule

// File: tb/tb_flag_shadow_stack.sv
// tb_flag_shadow_stack: directed vector table plus a mid-nesting reset sequence for flag_shadow_stack
module tb_flag_shadow_stack;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] flg_din = '0, flg_ld = '0, flg_set = '0, flg_clr = '0;
    logic       push = 1'b0, pop = 1'b0, err_clr = 1'b0;
    logic [1:0] flags_out;
    logic [2:0] depth_cnt;
    logic       full, empty, ovf_err, unf_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] din, ld, set, clr;
        logic       push, pop, ec;
        logic [1:0] e_flags;
        logic [2:0] e_cnt;
        logic       e_ovf, e_unf;
    } vec_t;

    vec_t tbl[$];
    vec_t hand[$];

    flag_shadow_stack #(.N_FLAGS(2), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flg_din   (flg_din),
        .flg_ld    (flg_ld),
        .flg_set   (flg_set),
        .flg_clr   (flg_clr),
        .push      (push),
        .pop       (pop),
        .err_clr   (err_clr),
        .flags_out (flags_out),
        .depth_cnt (depth_cnt),
        .full      (full),
        .empty     (empty),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic [1:0] din, ld, set, clr, input logic pu, po, ec,
                               input logic [1:0] ef, input logic [2:0] ecnt, input logic eo, eu);
        vec_t r;
        r.din = din; r.ld = ld; r.set = set; r.clr = clr;
        r.push = pu; r.pop = po; r.ec = ec;
        r.e_flags = ef; r.e_cnt = ecnt; r.e_ovf = eo; r.e_unf = eu;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] ef, input logic [2:0] ecnt, input logic eo, eu);
        chk({tag, " flags"}, 32'(flags_out), 32'(ef));
        chk({tag, " depth"}, 32'(depth_cnt), 32'(ecnt));
        chk({tag, " full"},  32'(full),      32'(ecnt == 3'd4));
        chk({tag, " empty"}, 32'(empty),     32'(ecnt == 3'd0));
        chk({tag, " ovf"},   32'(ovf_err),   32'(eo));
        chk({tag, " unf"},   32'(unf_err),   32'(eu));
    endtask

    task automatic run(input vec_t x, input string tag);
        @(negedge clk);
        flg_din = x.din; flg_ld = x.ld; flg_set = x.set; flg_clr = x.clr;
        push = x.push; pop = x.pop; err_clr = x.ec;
        @(posedge clk);
        #1;
        chk_all(tag, x.e_flags, x.e_cnt, x.e_ovf, x.e_unf);
    endtask

    task automatic idle();
        flg_din = '0; flg_ld = '0; flg_set = '0; flg_clr = '0;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        //                din    ld     set    clr    pu po ec  flags  cnt  ovf unf
        tbl.push_back(v(2'b00, 2'b11, 2'b11, 2'b01, 0, 0, 0, 2'b10, 3'd0, 0, 0)); // precedence
        tbl.push_back(v(2'b00, 2'b00, 2'b01, 2'b10, 0, 0, 0, 2'b01, 3'd0, 0, 0));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b01, 3'd1, 0, 0)); // nest push 01
        tbl.push_back(v(2'b00, 2'b00, 2'b10, 2'b01, 0, 0, 0, 2'b10, 3'd1, 0, 0));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b10, 3'd2, 0, 0)); // nest push 10
        tbl.push_back(v(2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 0, 2'b11, 3'd2, 0, 0));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b10, 3'd1, 0, 0)); // pop -> 10
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b01, 3'd0, 0, 0)); // pop -> 01
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b11, 0, 0, 0, 2'b00, 3'd0, 0, 0));
        tbl.push_back(v(2'b00, 2'b00, 2'b01, 2'b00, 0, 1, 0, 2'b01, 3'd0, 0, 1)); // underflow, set applied
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b01, 3'd0, 0, 0)); // err_clr
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 1, 2'b01, 3'd0, 0, 1)); // new error beats err_clr
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b01, 3'd0, 0, 0));
        tbl.push_back(v(2'b10, 2'b11, 2'b00, 2'b00, 1, 1, 0, 2'b10, 3'd1, 0, 0)); // push+pop empty = push
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b01, 3'd1, 0, 0)); // swap: entry now 10
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b11, 1, 1, 0, 2'b10, 3'd1, 0, 0)); // swap overrides clr
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b01, 3'd0, 0, 0)); // pop -> 01
        tbl.push_back(v(2'b10, 2'b11, 2'b00, 2'b00, 1, 0, 0, 2'b10, 3'd1, 0, 0)); // save 01
        tbl.push_back(v(2'b11, 2'b11, 2'b00, 2'b00, 1, 0, 0, 2'b11, 3'd2, 0, 0)); // save 10
        tbl.push_back(v(2'b00, 2'b11, 2'b00, 2'b00, 1, 0, 0, 2'b00, 3'd3, 0, 0)); // save 11
        tbl.push_back(v(2'b01, 2'b11, 2'b00, 2'b00, 1, 0, 0, 2'b01, 3'd4, 0, 0)); // save 00, full
        tbl.push_back(v(2'b10, 2'b11, 2'b00, 2'b00, 1, 0, 0, 2'b10, 3'd4, 1, 0)); // overflow, ld applied
        tbl.push_back(v(2'b00, 2'b00, 2'b11, 2'b00, 0, 1, 0, 2'b00, 3'd3, 1, 0)); // pop overrides set
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b11, 3'd2, 1, 0));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b10, 3'd1, 1, 0));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b01, 3'd0, 1, 0));
        tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b01, 3'd0, 0, 0));

        hand.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b01, 3'd1, 0, 0));
        hand.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b01, 3'd2, 0, 0));
        hand.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b01, 3'd3, 0, 0));
        hand.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b01, 3'd4, 0, 0));
        hand.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b01, 3'd4, 1, 0));
        hand.push_back(v(2'b00, 2'b00, 2'b11, 2'b00, 0, 1, 0, 2'b01, 3'd3, 1, 0));

        #1;
        chk_all("reset", 2'b00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("v%0d", i));
        for (int i = 0; i < hand.size(); i++) run(hand[i], $sformatf("h%0d", i));

        idle();
        #1;
        rst = 1'b1;
        #1;
        chk_all("midrst", 2'b00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run(v(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b00, 3'd0, 0, 1), "postrst_pop");
        run(v(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 3'd0, 0, 1), "postrst_hold");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flag_shadow_stack.md
FLAG_SHADOW_STACK -- requirements
Module: flag_shadow_stack

Interface
REQ-001 The block SHALL have parameter N_FLAGS, default 2, giving the number of flag bits (bit 0 = C, bit 1 = Z).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of shadow entries (legal range 1..16).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 flg_din  input  N_FLAGS  per-flag load data.
REQ-007 flg_ld  input  N_FLAGS  per-flag load enable.
REQ-008 flg_set  input  N_FLAGS  per-flag force-to-1.
REQ-009 flg_clr  input  N_FLAGS  per-flag force-to-0.
REQ-010 push  input  1  save live flags to the shadow stack (interrupt entry).
REQ-011 pop  input  1  restore live flags from the shadow stack (RETIE).
REQ-012 err_clr  input  1  clear sticky error flags.
REQ-013 flags_out  output  N_FLAGS  registered live flags.
REQ-014 depth_cnt  output  $clog2(DEPTH+1)  number of valid shadow entries.
REQ-015 full  output  1  depth_cnt == DEPTH (combinational from count).
REQ-016 empty  output  1  depth_cnt == 0 (combinational from count).
REQ-017 ovf_err  output  1  sticky: push attempted while full.
REQ-018 unf_err  output  1  sticky: pop attempted while empty.

Function
REQ-019 Without push or pop, each flag SHALL update at the next rising edge with precedence clr > set > ld > hold, independently per bit.
REQ-020 A valid pop (not empty) SHALL load all of flags_out from the top entry, overriding clr/set/ld for that cycle, and decrement depth_cnt.
REQ-021 A valid push (not full) SHALL write the pre-edge flags_out to entry depth_cnt and increment depth_cnt; clr/set/ld still apply to live flags in that cycle.
REQ-022 Push and pop in the same cycle while not empty SHALL swap: the top entry takes pre-edge flags_out, flags_out takes the old top entry, and depth_cnt is unchanged.
REQ-023 Push and pop in the same cycle while empty SHALL act as push alone and SHALL NOT set unf_err.
REQ-024 A push while full (and no pop) SHALL be dropped: stack and depth_cnt unchanged, ovf_err set, clr/set/ld still applied.
REQ-025 A pop while empty (and no push) SHALL be dropped: depth_cnt unchanged, unf_err set, clr/set/ld still applied.
REQ-026 ovf_err and unf_err SHALL stay set until err_clr or rst; a new error in the same cycle as err_clr SHALL leave the error set.
REQ-027 All outputs SHALL change only on a clock edge or rst, with one-cycle latency from inputs to flags_out and depth_cnt.
REQ-028 depth_cnt SHALL never exceed DEPTH or wrap below 0.

Reset
REQ-029 On rst, flags_out, depth_cnt, ovf_err and unf_err SHALL go to 0 immediately, so empty=1 and full=0.
REQ-030 Shadow entries SHALL NOT be reset; their contents are don't-care until written.
REQ-031 A rst asserted mid-nesting SHALL discard all saved entries; the first pop after reset SHALL be an underflow.

Structure
REQ-032 Package flag_pkg SHALL hold flag index constants FLAG_C=0, FLAG_Z=1 and the default N_FLAGS.
REQ-033 Sub-module flag_cell SHALL implement one flag bit: async reset, restore input with top precedence, then clr > set > ld > hold; the top level instantiates N_FLAGS of them.
REQ-034 The stack storage and the depth counter SHALL live in the top level as a register array indexed by depth_cnt.

Verification
REQ-035 Precedence: flg_clr=01, flg_set=11, flg_ld=11, flg_din=00 from flags 00 -> flags_out=10 after one edge.
REQ-036 Nesting: flags=01, push; flags set to 10, push; flags set to 11; pop -> 10, pop -> 01, depth_cnt 0->1->2->1->0, empty=1 at end.
REQ-037 Overflow: DEPTH=4, five pushes -> depth_cnt=4, full=1, ovf_err=1; four pops restore the first four saved values in reverse order.
REQ-038 Underflow: pop with empty and flg_set=01 -> flags_out=01, unf_err=1; err_clr -> unf_err=0 next edge.
REQ-039 Swap: depth_cnt=1 with entry 10, flags_out=01, push+pop -> flags_out=10, top entry=01, depth_cnt=1; pop -> 01.
REQ-040 Reset mid-operation: depth_cnt=3, ovf_err=1, assert rst between edges -> all outputs 0 before the next edge; the following pop sets unf_err.
